// File: rtl/axi4lite_master_if.sv
// rtl/axi4lite_master_if.sv - AXI4-Lite bus bundle between the initiator and a target
interface axi4lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  AW_VALID;
  logic                  AW_READY;
  logic [ADDR_WIDTH-1:0] AW_ADDR;
  logic                  W_VALID;
  logic                  W_READY;
  logic [DATA_WIDTH-1:0] W_DATA;
  logic                  B_VALID;
  logic                  B_READY;
  logic [1:0]            B_RESP;
  logic                  AR_VALID;
  logic                  AR_READY;
  logic [ADDR_WIDTH-1:0] AR_ADDR;
  logic                  R_VALID;
  logic                  R_READY;
  logic [DATA_WIDTH-1:0] R_DATA;
  logic [1:0]            R_RESP;

  modport master (
    output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );

  modport slave (
    input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );
endinterface

// File: rtl/axi4lite_master.sv
// rtl/axi4lite_master.sv - single-outstanding AXI4-Lite initiator with command/response port
// and a channel-stall watchdog.
module axi4lite_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      A_CLK,
  input  logic                      A_RST,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      timeout,
  axi4lite_master_if.master         axi
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
  } state_e;

  state_e                    state_q, state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      write_q, write_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                resp_q, resp_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                      in_wait;

  // VALIDs derive from state plus the sticky done flags, so they drop on their own handshake edge
  assign axi.AW_VALID = (state_q == WR_REQ) && !aw_done_q;
  assign axi.W_VALID  = (state_q == WR_REQ) && !w_done_q;
  assign axi.B_READY  = (state_q == WR_RESP);
  assign axi.AR_VALID = (state_q == RD_REQ);
  assign axi.R_READY  = (state_q == RD_RESP);
  assign axi.AW_ADDR  = addr_q;
  assign axi.AR_ADDR  = addr_q;
  assign axi.W_DATA   = wdata_q;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign timeout   = (cnt_q == CNT_MAX);

  assign aw_hs = axi.AW_VALID && axi.AW_READY;
  assign w_hs  = axi.W_VALID && axi.W_READY;
  assign b_hs  = axi.B_VALID && axi.B_READY;
  assign ar_hs = axi.AR_VALID && axi.AR_READY;
  assign r_hs  = axi.R_VALID && axi.R_READY;

  assign in_wait = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                   (state_q == RD_REQ) || (state_q == RD_RESP);

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d   = cmd_write;
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          resp_d  = axi.B_RESP;
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RD_REQ: begin
        if (ar_hs) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (r_hs) begin
          rdata_d = axi.R_DATA;
          resp_d  = axi.R_RESP;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog only observes; aborting would violate the VALID-until-handshake rule
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_wait && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi4lite_master.sv
// tb/tb_axi4lite_master.sv - randomized self-checking bench with slave model and reference memory
module tb_axi4lite_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          A_CLK = 1'b0;
  logic          A_RST;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          timeout;

  always #5 A_CLK = ~A_CLK;

  axi4lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4lite_master #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
    .axi(axi)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: per-channel READY latency, B/R issued after a programmable delay
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_wait = 0, r_wait = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, b_issued = 0, r_issued = 0;
  int skew_cycles = 0, wv_cycles = 0;
  logic p_aw = 0, p_w = 0, p_ar = 0, p_b = 0, p_r = 0;
  logic [AW-1:0] p_awaddr, p_araddr, slv_awaddr = '0, slv_araddr = '0;
  logic [DW-1:0] p_wdata, slv_wdata = '0;
  logic [DW-1:0] slv_mem [logic [AW-1:0]];

  initial begin
    axi.AW_READY = 0; axi.W_READY = 0; axi.B_VALID = 0; axi.B_RESP = 0;
    axi.AR_READY = 0; axi.R_VALID = 0; axi.R_DATA = 0; axi.R_RESP = 0;
    forever begin
      @(posedge A_CLK);
      #1;
      if (A_RST) begin
        axi.AW_READY = 0; axi.W_READY = 0; axi.B_VALID = 0; axi.B_RESP = 0;
        axi.AR_READY = 0; axi.R_VALID = 0; axi.R_DATA = 0; axi.R_RESP = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; b_issued = 0; r_issued = 0;
      end else begin
        if (p_aw) begin aw_hs++; slv_awaddr = p_awaddr; end
        if (p_w)  begin w_hs++;  slv_wdata  = p_wdata;  end
        if (p_ar) begin ar_hs++; slv_araddr = p_araddr; end
        if (p_b)  begin b_hs++;  axi.B_VALID = 0; end
        if (p_r)  begin r_hs++;  axi.R_VALID = 0; end
        if (axi.AW_VALID) begin axi.AW_READY = (aw_cnt >= aw_lat); aw_cnt++; end
        else begin axi.AW_READY = 0; aw_cnt = 0; end
        if (axi.W_VALID) begin axi.W_READY = (w_cnt >= w_lat); w_cnt++; end
        else begin axi.W_READY = 0; w_cnt = 0; end
        if (axi.AR_VALID) begin axi.AR_READY = (ar_cnt >= ar_lat); ar_cnt++; end
        else begin axi.AR_READY = 0; ar_cnt = 0; end
        if (axi.W_VALID && !axi.AW_VALID) skew_cycles++;
        if (axi.W_VALID) wv_cycles++;
        if (!axi.B_VALID && aw_hs > b_issued && w_hs > b_issued) begin
          if (b_wait >= b_lat) begin
            axi.B_VALID = 1; axi.B_RESP = slv_awaddr[5:4];
            slv_mem[slv_awaddr] = slv_wdata;
            b_issued++; b_wait = 0;
          end else b_wait++;
        end
        if (!axi.R_VALID && ar_hs > r_issued) begin
          if (r_wait >= r_lat) begin
            axi.R_VALID = 1; axi.R_RESP = slv_araddr[3:2];
            axi.R_DATA = slv_mem.exists(slv_araddr) ? slv_mem[slv_araddr] : '0;
            r_issued++; r_wait = 0;
          end else r_wait++;
        end
      end
      p_aw = axi.AW_VALID && axi.AW_READY; p_awaddr = axi.AW_ADDR;
      p_w  = axi.W_VALID && axi.W_READY;   p_wdata  = axi.W_DATA;
      p_ar = axi.AR_VALID && axi.AR_READY; p_araddr = axi.AR_ADDR;
      p_b  = axi.B_VALID && axi.B_READY;
      p_r  = axi.R_VALID && axi.R_READY;
    end
  end

  // Reference model: what the target memory should hold and what each response must carry
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW+2:0] expect_rsp(input logic w, input logic [AW-1:0] a);
    logic [DW-1:0] rd;
    if (w) return {1'b1, a[5:4], {DW{1'b0}}};
    rd = ref_mem.exists(a) ? ref_mem[a] : '0;
    return {1'b0, a[3:2], rd};
  endfunction

  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat);
    int n;
    n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
    while (!cmd_ready && n < 50) begin @(negedge A_CLK); n++; end
    check("cmd_accept", cmd_ready, 1);
    @(negedge A_CLK);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge A_CLK); lat++; end
    check("rsp_arrive", rsp_valid, 1);
  endtask

  task automatic take_rsp(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold);
    logic [DW+2:0] e;
    e = expect_rsp(w, a);
    check("rsp_write", rsp_write, e[DW+2]);
    check("rsp_resp", rsp_resp, e[DW+1:DW]);
    check("rsp_rdata", rsp_rdata, e[DW-1:0]);
    repeat (hold) @(negedge A_CLK);
    rsp_ready = 1;
    @(negedge A_CLK);
    rsp_ready = 0;
    check("idle_after_rsp", cmd_ready, 1);
    if (w) ref_mem[a] = d;
  endtask

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, s0, v0, b0, aw0, w0, ar0, r0, n;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW+2:0] e;

    A_RST = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
    repeat (3) @(negedge A_CLK);
    check("rst_valids", {axi.AW_VALID, axi.W_VALID, axi.AR_VALID, axi.B_READY, axi.R_READY}, 0);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_resp, timeout}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_addr", {axi.AW_ADDR, axi.AR_ADDR}, 0);
    check("rst_wdata", axi.W_DATA, 0);
    A_RST = 0;
    @(negedge A_CLK);
    check("rst_cmd_ready", cmd_ready, 1);

    // Zero-wait write
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    run_cmd(1, 32'h4, 32'hDEADBEEF, lat);
    check("zw_wr_latency", lat, 3);
    take_rsp(1, 32'h4, 32'hDEADBEEF, 0);
    check("zw_aw_hs", aw_hs - aw0, 1);
    check("zw_w_hs", w_hs - w0, 1);
    check("zw_b_hs", b_hs - b0, 1);
    check("zw_awaddr", slv_awaddr, 32'h4);
    check("zw_wdata", slv_wdata, 32'hDEADBEEF);

    // W_READY four cycles after AW_READY
    w_lat = 4; s0 = skew_cycles; v0 = wv_cycles; b0 = b_hs;
    run_cmd(1, 32'h4, 32'h12345678, lat);
    check("skew_latency", lat, 7);
    take_rsp(1, 32'h4, 32'h12345678, 1);
    check("skew_w_only_cycles", skew_cycles - s0, 4);
    check("skew_w_valid_cycles", wv_cycles - v0, 5);
    check("skew_b_hs", b_hs - b0, 1);
    w_lat = 0;

    // Read with nonzero response code
    run_cmd(0, 32'h4, '0, lat);
    check("rd_latency", lat, 3);
    check("rd_rdata_direct", rsp_rdata, 32'h12345678);
    check("rd_resp_direct", rsp_resp, 2'b01);
    take_rsp(0, 32'h4, '0, 0);

    // Response back-pressure with a second command waiting
    run_cmd(1, 32'h8, 32'hA5A5_0F0F, lat);
    e = expect_rsp(1, 32'h8);
    cmd_write = 0; cmd_addr = 32'h8; cmd_valid = 1;
    for (int k = 0; k < 5; k++) begin
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_rsp_stable", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, e});
      @(negedge A_CLK);
    end
    take_rsp(1, 32'h8, 32'hA5A5_0F0F, 0);
    run_cmd(0, 32'h8, '0, lat);
    check("bp_second_latency", lat, 3);
    take_rsp(0, 32'h8, '0, 0);

    // Watchdog with AR_READY stalled
    ar_lat = 12;
    cmd_write = 0; cmd_addr = 32'hC; cmd_valid = 1;
    @(negedge A_CLK);
    cmd_valid = 0;
    for (int k = 1; k <= 14; k++) begin
      check($sformatf("wd_timeout_c%0d", k), timeout, (k >= TO + 1 && k <= 13) ? 1 : 0);
      check($sformatf("wd_ar_valid_c%0d", k), axi.AR_VALID, (k <= 13) ? 1 : 0);
      @(negedge A_CLK);
    end
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge A_CLK); n++; end
    check("wd_rsp_arrive", rsp_valid, 1);
    take_rsp(0, 32'hC, '0, 0);
    ar_lat = 0;

    // Random traffic; waits stay below the watchdog threshold
    for (int t = 0; t < 40; t++) begin
      aw_lat = $urandom_range(0, 4); w_lat = $urandom_range(0, 4); b_lat = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 4); r_lat = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 15) * 4);
      d = $urandom;
      aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; b0 = b_hs; r0 = r_hs;
      run_cmd(w, a, d, lat);
      check("rnd_latency", lat, w ? (max2(aw_lat, w_lat) + b_lat + 3) : (ar_lat + r_lat + 3));
      take_rsp(w, a, d, $urandom_range(0, 3));
      if (w) begin
        check("rnd_aw_w_b_hs", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
        check("rnd_awaddr_wdata", {slv_awaddr, slv_wdata}, {a, d});
      end else begin
        check("rnd_ar_r_hs", {ar_hs - ar0, r_hs - r0}, {32'd1, 32'd1});
        check("rnd_araddr", slv_araddr, a);
      end
    end
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;

    // Leave nonzero read data in the response register, then reset during WR_RESP
    ref_mem[32'h10] = 32'hCAFE_0001;
    run_cmd(1, 32'h10, 32'hCAFE_0001, lat);
    take_rsp(1, 32'h10, 32'hCAFE_0001, 0);
    run_cmd(0, 32'h10, '0, lat);
    take_rsp(0, 32'h10, '0, 0);
    b_lat = 3;
    cmd_write = 1; cmd_addr = 32'h100; cmd_wdata = 32'h0BAD_F00D; cmd_valid = 1;
    @(negedge A_CLK);
    cmd_valid = 0;
    n = 0;
    while (!axi.B_VALID && n < 20) begin @(negedge A_CLK); n++; end
    check("mr_b_pending", {axi.B_VALID, axi.B_READY}, 2'b11);
    A_RST = 1;
    @(negedge A_CLK);
    check("mr_valids", {axi.AW_VALID, axi.W_VALID, axi.AR_VALID, axi.B_READY, axi.R_READY}, 0);
    check("mr_rsp", {rsp_valid, rsp_write, rsp_resp, timeout}, 0);
    check("mr_rdata", rsp_rdata, 0);
    check("mr_addr_data", {axi.AW_ADDR, axi.W_DATA}, 0);
    A_RST = 0;
    b_lat = 0;
    @(negedge A_CLK);
    check("mr_cmd_ready", cmd_ready, 1);
    run_cmd(0, 32'h10, '0, lat);
    check("mr_after_latency", lat, 3);
    take_rsp(0, 32'h10, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi4lite_master.md
# axi4lite_master

AXI4-Lite initiator that turns single-beat read/write commands from a local command port into AXI4-Lite transactions and returns the response to the command port. It sits on the manager side of the `axi4lite_if` bus and drives the existing AXI4-Lite slave and register bank for bring-up and self-checking tests. It handles one transaction at a time and has no outstanding-transaction pipelining. A watchdog counter flags a stalled channel.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, address width of AW_ADDR, AR_ADDR and cmd_addr
- AXI_DATA_WIDTH, 32, data width of W_DATA, R_DATA, cmd_wdata and rsp_rdata
- TIMEOUT_CYCLES, 256, wait cycles on a bus channel before `timeout` asserts (≥2)

Ports:
- A_CLK  in  1  clock; all logic on rising edge
- A_RST  in  1  reset, synchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when both are high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AXI_ADDR_WIDTH  target address
- cmd_wdata  in  AXI_DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both are high
- rsp_write  out  1  echoes cmd_write of the completed command
- rsp_rdata  out  AXI_DATA_WIDTH  captured R_DATA (0 for writes)
- rsp_resp  out  2  captured B_RESP or R_RESP
- timeout  out  1  current channel wait has reached TIMEOUT_CYCLES
- AW_VALID / AW_READY  out / in  1  write-address handshake
- AW_ADDR  out  AXI_ADDR_WIDTH  write address
- W_VALID / W_READY  out / in  1  write-data handshake
- W_DATA  out  AXI_DATA_WIDTH  write data
- B_VALID / B_READY  in / out  1  write-response handshake
- B_RESP  in  2  write response
- AR_VALID / AR_READY  out / in  1  read-address handshake
- AR_ADDR  out  AXI_ADDR_WIDTH  read address
- R_VALID / R_READY  in / out  1  read-data handshake
- R_DATA  in  AXI_DATA_WIDTH  read data
- R_RESP  in  2  read response

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- **IDLE:** `cmd_ready`=1 (combinational on state).
  - On `cmd_valid`, latch addr, wdata and write.
  - Write goes to WR_REQ; read goes to RD_REQ.
- **WR_REQ:** `AW_VALID` and `W_VALID` both rise on entry. Each is independent.
  - A channel drops on the edge of its own handshake and stays low.
  - Sticky flags `aw_done` and `w_done` record each handshake.
  - When both are done (same-cycle handshakes allowed), go to WR_RESP.
- **WR_RESP:** `B_READY`=1.
  - On B handshake, capture `B_RESP`, set `rsp_rdata`=0 and go to RSP.
- **RD_REQ:** `AR_VALID`=1. On AR handshake, drop it and go to RD_RESP.
- **RD_RESP:** `R_READY`=1.
  - On R handshake, capture `R_DATA` and `R_RESP`, then go to RSP.
- **RSP:** `rsp_valid`=1 with fields held stable. On `rsp_ready`, go to IDLE.
- **Address and data outputs:**
  - `AW_ADDR`, `AR_ADDR` and `W_DATA` come from the latched command.
  - They hold from acceptance until the next acceptance, so they are stable throughout VALID.
- **Watchdog:**
  - A counter clears on every state change and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - It saturates at TIMEOUT_CYCLES. `timeout` = (count == TIMEOUT_CYCLES).
  - The watchdog never aborts a transaction, because VALIDs must not drop before their handshake.
- **Response codes:** the block does not interpret them. A nonzero `rsp_resp` is passed through unchanged.

## Timing
- **Reset values:** state=IDLE, every AXI VALID/READY output 0, `rsp_valid`=0, `rsp_resp`=0, `rsp_rdata`=0, `rsp_write`=0, `timeout`=0, address and data outputs 0.
- **Reset mid-transaction:** all VALIDs drop at that edge and the pending command is discarded.
- **Acceptance:** command accepted at edge N puts VALID(s) high from cycle N+1.
- **Zero-wait write:** slave READYs high in N+1 and B in N+2 give `rsp_valid` in N+3. Minimum command-to-response latency is 3 cycles for both reads and writes.
- **Command back-pressure:** `cmd_ready` is 0 outside IDLE. The earliest next acceptance is the cycle after `rsp_ready`.
- **Out-of-order inputs:** a `B_VALID` in WR_REQ or an `R_VALID` in RD_REQ is ignored, because READY is 0.
- **Timeout timing:** `timeout` asserts exactly TIMEOUT_CYCLES cycles after entering a wait state with no handshake. It clears the cycle after the state advances.

## Test plan
- **Write, zero-wait slave:** write addr=0x4, data=0xDEADBEEF, READYs tied high, B_RESP=0.
  - AW and W each see exactly one handshake, with AW_ADDR=0x4 and W_DATA=0xDEADBEEF.
  - `rsp_valid` arrives 3 cycles after acceptance, with rsp_resp=0 and rsp_write=1.
- **Skewed write channels:** `W_READY` asserts 4 cycles after `AW_READY`.
  - AW_VALID drops after its handshake while W_VALID holds until its handshake.
  - Only one B handshake occurs.
- **Read via slave model:** read addr=0x4 with R_DATA=0x12345678 and R_RESP=2'b01.
  - rsp_rdata=0x12345678, rsp_resp=2'b01, rsp_write=0.
- **Response back-pressure:** `rsp_ready` is held low for 5 cycles while a second command is offered.
  - rsp fields stay stable and `cmd_ready` stays 0.
  - The second command is accepted the cycle after `rsp_ready`.
- **Watchdog:** TIMEOUT_CYCLES=8 and AR_READY held low.
  - `timeout` rises after 8 cycles in RD_REQ while AR_VALID stays high.
  - Releasing AR_READY completes the read and clears `timeout`.
- **Mid-transaction reset:** `A_RST` asserted in WR_RESP with B_VALID pending.
  - All outputs return to 0 at the next edge and `cmd_ready`=1 after release.
